// File: rtl/lalu_mem_pkg.sv
// ============================================================================
//  Module   : lalu_mem_pkg
//  Desc     : Shared widths, mode values and encodings for the memory
//             load/store port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lalu_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    localparam logic MODE_USER = 1'b0;
    localparam logic MODE_KERN = 1'b1;

    typedef enum logic [0:0] {
        ARB_RUN    = 1'b0,
        ARB_SWITCH = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } own_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_arbiter.sv
// ============================================================================
//  Module   : mem_access_arbiter
//  Desc     : Shares memory port B between the CPU LSU and the DMA engine and
//             sequences kernel/user mode changes around in-flight reads.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_arbiter
    import lalu_mem_pkg::*;
#(
    parameter int   ADDR_W       = DEF_ADDR_W,
    parameter int   DATA_W       = DEF_DATA_W,
    parameter int   STARVE_LIMIT = 4,
    parameter logic RESET_MODE   = MODE_KERN
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWdata,
    output logic              cpuGnt,
    output logic              cpuRvalid,
    output logic [DATA_W-1:0] cpuRdata,

    input  logic              dmaReq,
    input  logic              dmaWe,
    input  logic [ADDR_W-1:0] dmaAddr,
    input  logic [DATA_W-1:0] dmaWdata,
    output logic              dmaGnt,
    output logic              dmaRvalid,
    output logic [DATA_W-1:0] dmaRdata,

    input  logic              modeReq,
    input  logic              modeTarget,
    output logic              modeAck,
    output logic              operationMode,

    output logic [ADDR_W-1:0] memAccessAddress,
    output logic              memAccessWren,
    output logic [DATA_W-1:0] memAccessData,
    output logic              memAccessRden,
    input  logic [DATA_W-1:0] memAccessOutput
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_LIMIT);

    arb_state_t  state_q,  state_d;
    logic        mode_q,   mode_d;
    logic [3:0]  starve_q, starve_d;
    own_t        owner_q,  owner_d;

    logic        w_grant_ok;
    logic        w_dma_wins;
    logic        w_cpu_gnt;
    logic        w_dma_gnt;

    // ------------------------------------------------------------------
    // Grant and memory drive
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_ok       = (state_q == ARB_RUN) && !modeReq;
        w_dma_wins       = dmaReq && (starve_q == c_starve_max);
        w_cpu_gnt        = w_grant_ok && cpuReq && !w_dma_wins;
        w_dma_gnt        = w_grant_ok && dmaReq && (w_dma_wins || !cpuReq);

        memAccessAddress = '0;
        memAccessData    = '0;
        memAccessWren    = 1'b0;
        memAccessRden    = 1'b0;
        if (w_cpu_gnt) begin
            memAccessAddress = cpuAddr;
            memAccessData    = cpuWdata;
            memAccessWren    = cpuWe;
            memAccessRden    = !cpuWe;
        end else if (w_dma_gnt) begin
            memAccessAddress = dmaAddr;
            memAccessData    = dmaWdata;
            memAccessWren    = dmaWe;
            memAccessRden    = !dmaWe;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: mode FSM, starvation counter, read owner
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        starve_d = starve_q;
        owner_d  = OWN_NONE;

        case (state_q)
            ARB_RUN: begin
                if (modeReq) begin
                    mode_d  = modeTarget;
                    state_d = ARB_SWITCH;
                end
            end
            ARB_SWITCH: begin
                state_d = ARB_RUN;
            end
            default: begin
                state_d = ARB_RUN;
            end
        endcase

        // The counter freezes while grants are blocked by a mode change.
        if (w_grant_ok) begin
            if (w_dma_gnt || !dmaReq) begin
                starve_d = '0;
            end else if (w_cpu_gnt && (starve_q != c_starve_max)) begin
                starve_d = starve_q + 4'd1;
            end
        end

        if (w_cpu_gnt && !cpuWe) begin
            owner_d = OWN_CPU;
        end else if (w_dma_gnt && !dmaWe) begin
            owner_d = OWN_DMA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_RUN;
            mode_q   <= RESET_MODE;
            starve_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; read data is a passthrough of the memory output
    // ------------------------------------------------------------------
    assign cpuGnt        = w_cpu_gnt;
    assign dmaGnt        = w_dma_gnt;
    assign modeAck       = (state_q == ARB_SWITCH);
    assign operationMode = mode_q;
    assign cpuRvalid     = (owner_q == OWN_CPU);
    assign dmaRvalid     = (owner_q == OWN_DMA);
    assign cpuRdata      = cpuRvalid ? memAccessOutput : '0;
    assign dmaRdata      = dmaRvalid ? memAccessOutput : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
// ============================================================================
//  Module   : tb_mem_access_arbiter
//  Desc     : Directed and randomized self-checking bench for the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpuReq, cpuWe, dmaReq, dmaWe, modeReq, modeTarget;
    logic [AW-1:0] cpuAddr, dmaAddr;
    logic [DW-1:0] cpuWdata, dmaWdata, memAccessOutput;
    logic          cpuGnt, cpuRvalid, dmaGnt, dmaRvalid, modeAck, operationMode;
    logic [DW-1:0] cpuRdata, dmaRdata, memAccessData;
    logic [AW-1:0] memAccessAddress;
    logic          memAccessWren, memAccessRden;

    int checks = 0;
    int errors = 0;

    // Reference model: plain behavioural state derived from the rules
    logic m_mode;
    bit   m_sw;
    int   m_starve;
    bit   m_pc, m_pd;

    // Outputs sampled in the most recent step
    logic          s_cg, s_dg, s_crv, s_drv, s_ack, s_mode, s_wr, s_rd;
    logic [DW-1:0] s_crd, s_drd;

    always #5 clk = ~clk;

    mem_access_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT), .RESET_MODE(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
        .cpuGnt(cpuGnt), .cpuRvalid(cpuRvalid), .cpuRdata(cpuRdata),
        .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWdata(dmaWdata),
        .dmaGnt(dmaGnt), .dmaRvalid(dmaRvalid), .dmaRdata(dmaRdata),
        .modeReq(modeReq), .modeTarget(modeTarget), .modeAck(modeAck),
        .operationMode(operationMode),
        .memAccessAddress(memAccessAddress), .memAccessWren(memAccessWren),
        .memAccessData(memAccessData), .memAccessRden(memAccessRden),
        .memAccessOutput(memAccessOutput)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = 1'b1;
        m_sw     = 1'b0;
        m_starve = 0;
        m_pc     = 1'b0;
        m_pd     = 1'b0;
    endtask

    // Called at a falling edge with inputs already applied; returns at the
    // next falling edge after the model has absorbed the rising edge.
    task automatic step();
        bit            blocked, e_cg, e_dg;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        #1;
        blocked = m_sw || modeReq;
        e_cg = 1'b0;
        e_dg = 1'b0;
        if (!blocked) begin
            if (dmaReq && m_starve >= LIMIT) e_dg = 1'b1;
            else if (cpuReq)                 e_cg = 1'b1;
            else if (dmaReq)                 e_dg = 1'b1;
        end
        e_addr = e_cg ? cpuAddr  : (e_dg ? dmaAddr  : '0);
        e_data = e_cg ? cpuWdata : (e_dg ? dmaWdata : '0);

        s_cg  = cpuGnt;    s_dg  = dmaGnt;
        s_crv = cpuRvalid; s_drv = dmaRvalid;
        s_crd = cpuRdata;  s_drd = dmaRdata;
        s_ack = modeAck;   s_mode = operationMode;
        s_wr  = memAccessWren; s_rd = memAccessRden;

        chk("cpuGnt",    s_cg,  e_cg);
        chk("dmaGnt",    s_dg,  e_dg);
        chk("cpuRvalid", s_crv, m_pc);
        chk("dmaRvalid", s_drv, m_pd);
        chk("cpuRdata",  s_crd, m_pc ? memAccessOutput : '0);
        chk("dmaRdata",  s_drd, m_pd ? memAccessOutput : '0);
        chk("modeAck",   s_ack, m_sw);
        chk("opMode",    s_mode, m_mode);
        chk("memAddr",   memAccessAddress, e_addr);
        chk("memData",   memAccessData, e_data);
        chk("memWren",   s_wr, (e_cg && cpuWe) || (e_dg && dmaWe));
        chk("memRden",   s_rd, (e_cg && !cpuWe) || (e_dg && !dmaWe));

        @(posedge clk);
        m_pc = e_cg && !cpuWe;
        m_pd = e_dg && !dmaWe;
        if (!blocked) begin
            if (e_dg || !dmaReq)               m_starve = 0;
            else if (e_cg && m_starve < LIMIT) m_starve++;
        end
        if (!m_sw && modeReq) begin
            m_mode = modeTarget;
            m_sw   = 1'b1;
        end else begin
            m_sw = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cpuReq = 0; dmaReq = 0; modeReq = 0;
    endtask

    initial begin
        logic [3:0] pat_cpu;
        bit         cpu_new, dma_new;
        rst_n = 1'b0;
        idle();
        cpuWe = 0; dmaWe = 0; modeTarget = 0;
        cpuAddr = '0; dmaAddr = '0; cpuWdata = '0; dmaWdata = '0;
        memAccessOutput = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cpuRvalid", cpuRvalid, 1'b0);
        chk("rst_dmaRvalid", dmaRvalid, 1'b0);
        chk("rst_modeAck",   modeAck,   1'b0);
        chk("rst_opMode",    operationMode, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: CPU read and passthrough return
        cpuReq = 1; cpuWe = 0; cpuAddr = 16'h0010;
        step();
        chk("t1_gnt", s_cg, 1'b1);
        cpuReq = 0; memAccessOutput = 32'hDEADBEEF;
        step();
        chk("t1_rvalid", s_crv, 1'b1);
        chk("t1_rdata",  s_crd, 32'hDEADBEEF);
        chk("t1_dmarv",  s_drv, 1'b0);

        // 2: starvation forces DMA on the fifth contested cycle
        cpuReq = 1; dmaReq = 1; cpuWe = 0; dmaWe = 0;
        cpuAddr = 16'h0020; dmaAddr = 16'h0030;
        pat_cpu = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i < 4) pat_cpu[i] = s_cg;
            if (i == 4) chk("t2_dma5", s_dg, 1'b1);
            if (i == 5) chk("t2_cpu6", s_cg, 1'b1);
        end
        chk("t2_cpu1to4", pat_cpu, 4'b1111);
        idle();
        step();

        // 3: CPU write, no return
        cpuReq = 1; cpuWe = 1; cpuAddr = 16'h0100; cpuWdata = 32'h12345678;
        step();
        chk("t3_wren", s_wr, 1'b1);
        chk("t3_rden", s_rd, 1'b0);
        idle();
        step();
        chk("t3_norv", s_crv, 1'b0);

        // 4: mode change behind an in-flight DMA read
        dmaReq = 1; dmaWe = 0; dmaAddr = 16'h0200;
        step();
        dmaReq = 0; cpuReq = 1; cpuWe = 0; modeReq = 1; modeTarget = 0;
        memAccessOutput = 32'hA5A55A5A;
        step();
        chk("t4_dmarv",  s_drv, 1'b1);
        chk("t4_dmard",  s_drd, 32'hA5A55A5A);
        chk("t4_blk_t",  s_cg,  1'b0);
        modeReq = 0;
        step();
        chk("t4_blk_t1", s_cg,  1'b0);
        chk("t4_ack",    s_ack, 1'b1);
        chk("t4_mode",   s_mode, 1'b0);
        step();
        chk("t4_gnt_t2", s_cg,  1'b1);
        idle();
        step();

        // 5: same-mode request still takes two blocked cycles
        cpuReq = 1; cpuWe = 1; modeReq = 1; modeTarget = 0;
        step();
        chk("t5_blk0", s_cg, 1'b0);
        modeReq = 0;
        step();
        chk("t5_blk1", s_cg, 1'b0);
        chk("t5_ack",  s_ack, 1'b1);
        chk("t5_mode", s_mode, 1'b0);
        step();
        chk("t5_gnt",  s_cg, 1'b1);
        idle();
        step();

        // 6: asynchronous reset discards a pending return
        cpuReq = 1; cpuWe = 0; cpuAddr = 16'h0040;
        step();
        chk("t6_gnt", s_cg, 1'b1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rv",   cpuRvalid, 1'b0);
        chk("t6_mode", operationMode, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Randomized traffic: requesters hold until granted
        cpu_new = 1; dma_new = 1;
        for (int c = 0; c < 3000; c++) begin
            if (cpu_new) begin
                cpuReq   = ($urandom_range(0, 3) != 0);
                cpuWe    = $urandom_range(0, 1) == 1;
                cpuAddr  = AW'($urandom);
                cpuWdata = $urandom;
            end
            if (dma_new) begin
                dmaReq   = ($urandom_range(0, 3) != 0);
                dmaWe    = $urandom_range(0, 1) == 1;
                dmaAddr  = AW'($urandom);
                dmaWdata = $urandom;
            end
            modeReq         = ($urandom_range(0, 15) == 0);
            modeTarget      = $urandom_range(0, 1) == 1;
            memAccessOutput = $urandom;
            step();
            cpu_new = !cpuReq || s_cg;
            dma_new = !dmaReq || s_dg;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
